regfile_hilo: RTL and testbench

Architectural state sink at the write-back end of the MIPS32 pipeline. It consumes the registered write-back outputs of the MEM/WB stage: GPR write address, data and enable, plus HI/LO data and enable. It holds the 32x32 general-purpose register file and the HI/LO pair. It serves two combinational GPR read ports and the HI/LO read port to decode/execute, with same-cycle write-to-read bypass, and keeps a wrapping retire counter for debug.

---
 rtl/regfile_hilo.sv | 89 ++++++++
 tb/tb_regfile_hilo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_hilo.sv
// Write-back state sink: 31 GPRs (r0 hard-wired to zero) and the HI/LO pair, each with
// same-cycle write-to-read bypass, plus a wrapping count of write-back cycles.
module regfile_hilo (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        hilo_we,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] retire_cnt
);

    logic [31:0] regs [1:31];
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] retire_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
            hi_q     <= '0;
            lo_q     <= '0;
            retire_q <= '0;
        end else begin
            if (we && (waddr != 5'd0)) begin
                regs[waddr] <= wdata;
            end
            if (hilo_we) begin
                hi_q <= hi_i;
                lo_q <= lo_i;
            end
            // One retire per write-back cycle, even if both enables fire or r0 is targeted.
            if (we || hilo_we) begin
                retire_q <= retire_q + 32'd1;
            end
        end
    end

    always_comb begin
        rdata1 = '0;
        if (rst && (raddr1 != 5'd0) && re1) begin
            if (we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst && (raddr2 != 5'd0) && re2) begin
            if (we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
        end
    end

    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (rst) begin
            if (hilo_we) begin
                hi_o = hi_i;
                lo_o = lo_i;
            end else begin
                hi_o = hi_q;
                lo_o = lo_q;
            end
        end
    end

    assign retire_cnt = retire_q;

endmodule

// File: tb/tb_regfile_hilo.sv
// Directed bench for regfile_hilo: a vector table for read/bypass/HI-LO/counter
// behaviour plus hand sequences for reset, counter wrap and reset mid-stream.
module tb_regfile_hilo;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hilo_we;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] retire_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_hilo dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .hilo_we    (hilo_we),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .re1        (re1),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .re2        (re2),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        hilo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic [31:0] e_r1;
        logic [31:0] e_r2;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; waddr = '0; wdata = '0;
        hilo_we = 1'b0; hi_i = '0; lo_i = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hi"}, hi_o, 32'h0);
        check({tag, "_lo"}, lo_o, 32'h0);
        check({tag, "_cnt"}, retire_cnt, 32'h0);
    endtask

    task automatic read_all_zero(input string tag);
        re1 = 1'b1; re2 = 1'b1;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            #1;
            check($sformatf("%s_r1_%0d", tag, a), rdata1, 32'h0);
            check($sformatf("%s_r2_%0d", tag, 31 - a), rdata2, 32'h0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                we  waddr wdata          hwe hi             lo             re1 ra1 re2 ra2  e_r1           e_r2           e_hi           e_lo           e_cnt
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 32'h0,        32'h0,        1'b1, 5'd5,  1'b0, 5'd5,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'd0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        32'd1};
        vecs[2]  = '{1'b1, 5'd0,  32'h12345678, 1'b0, 32'h0,        32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'd1};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 5'd0,  1'b1, 5'd5,  32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        32'd2};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 32'hAAAA0001, 32'h5555FFFE, 1'b1, 5'd5,  1'b0, 5'd0,  32'hDEADBEEF, 32'h0,        32'hAAAA0001, 32'h5555FFFE, 32'd2};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h11111111, 32'h22222222, 1'b0, 5'd5,  1'b0, 5'd0,  32'h0,        32'h0,        32'hAAAA0001, 32'h5555FFFE, 32'd3};
        vecs[6]  = '{1'b1, 5'd7,  32'hCAFEF00D, 1'b0, 32'h0,        32'h0,        1'b1, 5'd7,  1'b1, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF, 32'hAAAA0001, 32'h5555FFFE, 32'd3};
        vecs[7]  = '{1'b1, 5'd5,  32'h00000055, 1'b1, 32'h00000001, 32'h00000002, 1'b1, 5'd7,  1'b1, 5'd5,  32'hCAFEF00D, 32'h00000055, 32'h00000001, 32'h00000002, 32'd4};
        vecs[8]  = '{1'b1, 5'd31, 32'h80000001, 1'b1, 32'h00000003, 32'h00000004, 1'b1, 5'd5,  1'b1, 5'd31, 32'h00000055, 32'h80000001, 32'h00000003, 32'h00000004, 32'd5};
        vecs[9]  = '{1'b1, 5'd31, 32'h00000007, 1'b1, 32'h00000005, 32'h00000006, 1'b1, 5'd31, 1'b1, 5'd31, 32'h00000007, 32'h00000007, 32'h00000005, 32'h00000006, 32'd6};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 5'd31, 1'b1, 5'd7,  32'h00000007, 32'hCAFEF00D, 32'h00000005, 32'h00000006, 32'd7};

        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        read_all_zero("post_reset");
        idle_inputs();

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            hilo_we = vecs[i].hilo_we; hi_i = vecs[i].hi; lo_i = vecs[i].lo;
            re1 = vecs[i].re1; raddr1 = vecs[i].raddr1;
            re2 = vecs[i].re2; raddr2 = vecs[i].raddr2;
            #1;
            check($sformatf("v%0d_rdata1", i), rdata1, vecs[i].e_r1);
            check($sformatf("v%0d_rdata2", i), rdata2, vecs[i].e_r2);
            check($sformatf("v%0d_hi", i), hi_o, vecs[i].e_hi);
            check($sformatf("v%0d_lo", i), lo_o, vecs[i].e_lo);
            check($sformatf("v%0d_cnt", i), retire_cnt, vecs[i].e_cnt);
        end

        // Counter wrap from all-ones.
        @(negedge clk);
        idle_inputs();
        dut.retire_q = 32'hFFFF_FFFF;
        #1;
        check("wrap_pre", retire_cnt, 32'hFFFF_FFFF);
        we = 1'b1; waddr = 5'd0;
        @(negedge clk);
        idle_inputs();
        #1;
        check("wrap_post", retire_cnt, 32'h0000_0000);
        @(negedge clk);
        #1;
        check("wrap_hold", retire_cnt, 32'h0000_0000);

        // Back-to-back writes r1..r31, then read everything back from storage.
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            we = 1'b1; waddr = 5'(a); wdata = 32'(a) * 32'h01010101;
        end
        @(negedge clk);
        idle_inputs();
        re1 = 1'b1; re2 = 1'b1;
        for (int a = 1; a < 32; a++) begin
            raddr1 = 5'(a);
            raddr2 = 5'(32 - a);
            #1;
            check($sformatf("fill_r1_%0d", a), rdata1, 32'(a) * 32'h01010101);
            check($sformatf("fill_r2_%0d", 32 - a), rdata2, 32'(32 - a) * 32'h01010101);
        end
        check("fill_cnt", retire_cnt, 32'd31);

        // Reset asserted between edges while a write is pending.
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; wdata = 32'h99999999;
        hilo_we = 1'b1; hi_i = 32'h12121212; lo_i = 32'h34343434;
        re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd3;
        #1;
        check("pre_rst_bypass", rdata1, 32'h99999999);
        rst = 1'b0;
        #1;
        check("rst_r1", rdata1, 32'h0);
        check("rst_r2", rdata2, 32'h0);
        check_all_zero("rst_mid");
        // Write presented on an edge while rst is low must be dropped.
        waddr = 5'd3; wdata = 32'h33333333;
        @(posedge clk);
        #1;
        check("rst_edge_cnt", retire_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        #1;
        check_all_zero("after_rst");
        read_all_zero("after_rst");

        // First edge after release accepts a write.
        @(negedge clk);
        we = 1'b1; waddr = 5'd4; wdata = 32'h00000ABC;
        @(negedge clk);
        idle_inputs();
        re1 = 1'b1; raddr1 = 5'd4;
        #1;
        check("release_write", rdata1, 32'h00000ABC);
        check("release_cnt", retire_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
